onehot_key_capture: RTL and testbench

//  Upstream stage of the 8-to-3 encoder. Takes eight raw push-button inputs, synchronises
//  and debounces them, and captures a single pressed key as a registered one-hot vector.

---
 rtl/onehot_key_capture_if.sv | 41 ++++
 rtl/onehot_key_capture.sv | 159 +++++++++++++++
 tb/tb_onehot_key_capture.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/onehot_key_capture_if.sv
// Purpose : bundles the key-capture stage's data signals for the encoder front end.
// Latency : n/a (wiring only).
// Backpressure: none; every signal is sampled or driven every cycle.
//
// Signals:
//   key_in    raw asynchronous buttons, 1 = pressed      (master -> slave)
//   clear     synchronous request to zero onehot         (master -> slave)
//   onehot    captured one-hot key or 0, encoder input   (slave -> master)
//   strobe    one-cycle pulse on each new capture        (slave -> master)
//   multi_err one-cycle pulse on a multi-key press       (slave -> master)
//   db_keys   debounced key vector, observability only   (slave -> master)
interface onehot_key_capture_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] key_in;
  logic             clear;
  logic [WIDTH-1:0] onehot;
  logic             strobe;
  logic             multi_err;
  logic [WIDTH-1:0] db_keys;

  // master: the environment driving the buttons and consuming the capture
  modport master (
    output key_in,
    output clear,
    input  onehot,
    input  strobe,
    input  multi_err,
    input  db_keys
  );

  // slave: the capture block itself
  modport slave (
    input  key_in,
    input  clear,
    output onehot,
    output strobe,
    output multi_err,
    output db_keys
  );
endinterface

// File: rtl/onehot_key_capture.sv
// Purpose : synchronise + debounce raw buttons, capture a single pressed key as one-hot.
// Latency : key stable before edge 1 -> db_keys at edge 2+DEBOUNCE_CYCLES, onehot/strobe one edge later.
// Backpressure: none; the encoder input is a registered level, strobe/multi_err are single-cycle pulses.
//
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset, overrides everything
//   bus  slave modport of onehot_key_capture_if (key_in, clear in; onehot, strobe,
//        multi_err, db_keys out)
//
// DEBOUNCE_CYCLES must be >= 2 and CNT_W must be wide enough to hold DEBOUNCE_CYCLES-1.
module onehot_key_capture #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  onehot_key_capture_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // no debounced key; ready to capture
    ST_HELD    = 2'd1,  // a single key was captured; waiting for full release
    ST_LOCKOUT = 2'd2   // a multi-key press was seen; waiting for full release
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]            s1_q,        s1_d;
  logic [WIDTH-1:0]            s2_q,        s2_d;
  logic [WIDTH-1:0]            db_q,        db_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q,       cnt_d;
  state_t                      state_q,     state_d;
  logic [WIDTH-1:0]            onehot_q,    onehot_d;
  logic                        strobe_q,    strobe_d;
  logic                        multi_err_q, multi_err_d;

  // Classification of the debounced vector
  logic db_any;
  logic db_single;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser: raw buttons are asynchronous to clk.
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_d = bus.key_in;
    s2_d = s1_q;
  end

  // ---------------------------------------------------------------------------
  // Per-bit debounce. The counter tracks how many consecutive synchronised
  // samples have disagreed with the debounced value; the bit only flips on the
  // DEBOUNCE_CYCLES-th disagreeing sample, and any agreeing sample restarts
  // the count, so short glitches never reach db_keys.
  // ---------------------------------------------------------------------------
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        db_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Exactly-one-bit test: clearing the lowest set bit leaves zero only when a
  // single bit was set.
  // ---------------------------------------------------------------------------
  always_comb begin
    db_any    = |db_q;
    db_single = db_any && ((db_q & (db_q - WIDTH'(1))) == '0);
  end

  // ---------------------------------------------------------------------------
  // Capture FSM, acting on the debounced vector. Pulses default low every
  // cycle; onehot holds until a new capture or a clear.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    onehot_d    = onehot_q;
    strobe_d    = 1'b0;
    multi_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (db_single) begin
          onehot_d = db_q;
          strobe_d = 1'b1;
          state_d  = ST_HELD;
        end else if (db_any) begin
          // onehot keeps its previous capture; only the error pulse is raised
          multi_err_d = 1'b1;
          state_d     = ST_LOCKOUT;
        end
      end
      // First key wins in HELD; extra keys or partial releases are ignored
      // in both waiting states until every key is up.
      ST_HELD, ST_LOCKOUT: begin
        if (!db_any) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // clear beats a simultaneous capture: the key is still consumed (state
    // advances to HELD above) but the encoder never sees it and no strobe fires.
    if (bus.clear) begin
      onehot_d = '0;
      strobe_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      db_q        <= '0;
      cnt_q       <= '0;
      state_q     <= ST_IDLE;
      onehot_q    <= '0;
      strobe_q    <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      db_q        <= db_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      onehot_q    <= onehot_d;
      strobe_q    <= strobe_d;
      multi_err_q <= multi_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all straight from flops
  // ---------------------------------------------------------------------------
  assign bus.onehot    = onehot_q;
  assign bus.strobe    = strobe_q;
  assign bus.multi_err = multi_err_q;
  assign bus.db_keys   = db_q;

endmodule

// File: tb/tb_onehot_key_capture.sv
// Bench for onehot_key_capture: directed scenarios plus random key traffic,
// every cycle compared against a behavioural reference model.
module tb_onehot_key_capture;
  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  onehot_key_capture_if #(.WIDTH(W)) bus ();

  onehot_key_capture #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------------------------------------------------------------------
  // Reference model. A raw sample reaches the debouncer two edges after it is
  // taken; a debounced bit flips once the last D samples seen by the debouncer
  // all disagree with it. The capture rules are applied to the debounced value
  // as it stood before the edge.
  // ---------------------------------------------------------------------------
  logic [W-1:0] m_pipe[$];   // raw samples in flight through the synchroniser
  logic [W-1:0] m_hist[$];   // samples seen by the debouncer, newest last
  logic [W-1:0] m_db;
  logic [W-1:0] m_onehot;
  logic         m_strobe;
  logic         m_err;
  int           m_mode;      // 0 = idle, 1 = key captured, 2 = locked out

  always @(posedge clk) begin : ref_model
    logic [W-1:0] seen;
    logic [W-1:0] db_old;
    logic         all_diff;
    if (rst) begin
      m_pipe.delete();
      m_pipe.push_back('0);
      m_pipe.push_back('0);
      m_hist.delete();
      m_db     = '0;
      m_onehot = '0;
      m_strobe = 1'b0;
      m_err    = 1'b0;
      m_mode   = 0;
    end else begin
      seen = m_pipe.pop_front();
      m_pipe.push_back(bus.key_in);
      m_hist.push_back(seen);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      db_old = m_db;
      for (int i = 0; i < W; i++) begin
        all_diff = (m_hist.size() == D);
        foreach (m_hist[j]) if (m_hist[j][i] == db_old[i]) all_diff = 1'b0;
        if (all_diff) m_db[i] = ~db_old[i];
      end
      m_strobe = 1'b0;
      m_err    = 1'b0;
      if (m_mode == 0) begin
        if ($countones(db_old) == 1) begin
          m_onehot = db_old;
          m_strobe = 1'b1;
          m_mode   = 1;
        end else if ($countones(db_old) >= 2) begin
          m_err  = 1'b1;
          m_mode = 2;
        end
      end else if (db_old == '0) begin
        m_mode = 0;
      end
      if (bus.clear) begin
        m_onehot = '0;
        m_strobe = 1'b0;
      end
    end
  end

  // One clock of stimulus; outputs are settled 1 time unit after the edge.
  task automatic tick(input logic [W-1:0] k, input logic c, input logic r);
    @(negedge clk);
    bus.key_in = k;
    bus.clear  = c;
    rst        = r;
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset;
    tick('0, 1'b0, 1'b1);
    tick('0, 1'b0, 1'b1);
    for (int e = 1; e <= 20; e++) begin
      tick('0, 1'b0, 1'b0);
      vectors++;
      if ({bus.onehot, bus.strobe, bus.multi_err, bus.db_keys} !== {8'h00, 1'b0, 1'b0, 8'h00}) begin
        miscompares++;
        $display("FAIL reset_idle e=%0d: got %h want %h", e,
                 {bus.onehot, bus.strobe, bus.multi_err, bus.db_keys}, 18'h0);
      end
    end
  endtask

  task automatic test_single;
    int strobes;
    tick('0, 1'b0, 1'b1);
    for (int e = 1; e <= 12; e++) begin
      tick(8'h08, 1'b0, 1'b0);
      vectors++;
      if (bus.strobe !== (e == 7) || bus.onehot !== ((e >= 7) ? 8'h08 : 8'h00)) begin
        miscompares++;
        $display("FAIL single_08 e=%0d: strobe=%b onehot=%h want strobe=%b onehot=%h", e,
                 bus.strobe, bus.onehot, (e == 7), ((e >= 7) ? 8'h08 : 8'h00));
      end
    end
    for (int e = 1; e <= 8; e++) tick('0, 1'b0, 1'b0);
    strobes = 0;
    for (int e = 1; e <= 10; e++) begin
      tick(8'h40, 1'b0, 1'b0);
      if (bus.strobe === 1'b1) strobes++;
      vectors++;
      if ({bus.onehot, bus.strobe, bus.multi_err, bus.db_keys} !== {m_onehot, m_strobe, m_err, m_db}) begin
        miscompares++;
        $display("FAIL single_40_model e=%0d: got %h want %h", e,
                 {bus.onehot, bus.strobe, bus.multi_err, bus.db_keys}, {m_onehot, m_strobe, m_err, m_db});
      end
    end
    vectors++;
    if (strobes != 1 || bus.onehot !== 8'h40) begin
      miscompares++;
      $display("FAIL single_40: strobes=%0d onehot=%h want strobes=1 onehot=40", strobes, bus.onehot);
    end
    for (int e = 1; e <= 8; e++) tick('0, 1'b0, 1'b0);
  endtask

  task automatic test_glitch;
    for (int e = 1; e <= 11; e++) begin
      tick((e <= 3) ? 8'h01 : 8'h00, 1'b0, 1'b0);
      vectors++;
      if (bus.db_keys !== 8'h00 || bus.strobe !== 1'b0 || bus.onehot !== 8'h40) begin
        miscompares++;
        $display("FAIL glitch e=%0d: db=%h strobe=%b onehot=%h want db=00 strobe=0 onehot=40", e,
                 bus.db_keys, bus.strobe, bus.onehot);
      end
    end
  endtask

  task automatic test_multi;
    for (int e = 1; e <= 10; e++) begin
      tick(8'h24, 1'b0, 1'b0);
      vectors++;
      if (bus.multi_err !== (e == 7) || bus.strobe !== 1'b0 || bus.onehot !== 8'h40) begin
        miscompares++;
        $display("FAIL multi_24 e=%0d: err=%b strobe=%b onehot=%h want err=%b strobe=0 onehot=40", e,
                 bus.multi_err, bus.strobe, bus.onehot, (e == 7));
      end
    end
    for (int e = 1; e <= 12; e++) begin
      tick(8'h04, 1'b0, 1'b0);
      vectors++;
      if (bus.multi_err !== 1'b0 || bus.strobe !== 1'b0 || bus.onehot !== 8'h40) begin
        miscompares++;
        $display("FAIL multi_partial e=%0d: err=%b strobe=%b onehot=%h want 0 0 40", e,
                 bus.multi_err, bus.strobe, bus.onehot);
      end
    end
    for (int e = 1; e <= 8; e++) tick('0, 1'b0, 1'b0);
  endtask

  task automatic test_add_clear;
    for (int e = 1; e <= 10; e++) tick(8'h02, 1'b0, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      tick(8'h82, 1'b0, 1'b0);
      vectors++;
      if (bus.onehot !== 8'h02 || bus.strobe !== 1'b0 || bus.multi_err !== 1'b0) begin
        miscompares++;
        $display("FAIL add_key e=%0d: onehot=%h strobe=%b err=%b want 02 0 0", e,
                 bus.onehot, bus.strobe, bus.multi_err);
      end
    end
    for (int e = 1; e <= 2; e++) begin
      tick(8'h82, (e == 1), 1'b0);
      vectors++;
      if (bus.onehot !== 8'h00 || bus.strobe !== 1'b0) begin
        miscompares++;
        $display("FAIL clear e=%0d: onehot=%h strobe=%b want 00 0", e, bus.onehot, bus.strobe);
      end
    end
    for (int e = 1; e <= 8; e++) tick('0, 1'b0, 1'b0);
  endtask

  task automatic test_clear_capture;
    for (int e = 1; e <= 12; e++) begin
      tick(8'h20, (e == 7), 1'b0);
      vectors++;
      if (bus.onehot !== 8'h00 || bus.strobe !== 1'b0) begin
        miscompares++;
        $display("FAIL clear_capture e=%0d: onehot=%h strobe=%b want 00 0", e, bus.onehot, bus.strobe);
      end
    end
    for (int e = 1; e <= 8; e++) tick('0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    for (int e = 1; e <= 10; e++) tick(8'h10, 1'b0, 1'b0);
    tick(8'h10, 1'b0, 1'b1);
    vectors++;
    if ({bus.onehot, bus.strobe, bus.multi_err, bus.db_keys} !== 18'h0) begin
      miscompares++;
      $display("FAIL reset_mid: got %h want %h", {bus.onehot, bus.strobe, bus.multi_err, bus.db_keys}, 18'h0);
    end
    for (int e = 1; e <= 10; e++) begin
      tick(8'h10, 1'b0, 1'b0);
      vectors++;
      if (bus.strobe !== (e == 7) || bus.onehot !== ((e >= 7) ? 8'h10 : 8'h00)) begin
        miscompares++;
        $display("FAIL recapture e=%0d: strobe=%b onehot=%h want strobe=%b onehot=%h", e,
                 bus.strobe, bus.onehot, (e == 7), ((e >= 7) ? 8'h10 : 8'h00));
      end
    end
    for (int e = 1; e <= 8; e++) tick('0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    for (int s = 0; s < 300; s++) begin
      logic [W-1:0] k;
      int           kind;
      int           len;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 12);
      if (kind <= 4)      k = W'(1) << $urandom_range(0, W - 1);
      else if (kind <= 7) k = W'($urandom);
      else                k = '0;
      for (int t = 0; t < len; t++) begin
        tick(k, ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
        vectors++;
        if ({bus.onehot, bus.strobe, bus.multi_err, bus.db_keys} !== {m_onehot, m_strobe, m_err, m_db}
            || $countones(bus.onehot) > 1 || (bus.strobe && bus.multi_err)) begin
          miscompares++;
          $display("FAIL random s=%0d t=%0d key=%h: got %h want %h", s, t, k,
                   {bus.onehot, bus.strobe, bus.multi_err, bus.db_keys}, {m_onehot, m_strobe, m_err, m_db});
        end
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.key_in = '0;
    bus.clear  = 1'b0;
    test_reset();
    test_single();
    test_glitch();
    test_multi();
    test_add_clear();
    test_clear_capture();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
